interval_timer: RTL and testbench

Countdown timer feeding the traffic-light controller: consumes its `interval` code and `start_timer` request and returns a single-cycle `expired` pulse when the selected time has elapsed. Holds the programmable time parameters (base, extended, yellow). Programs them from the switch inputs while `Prog_Sync` is high. Contains the seconds prescaler, so the controller only ever sees whole-second intervals.

---
 rtl/traffic_pkg.sv | 49 ++++
 rtl/tick_gen.sv | 34 +++
 rtl/interval_timer.sv | 105 ++++++++++
 tb/tb_interval_timer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared codes, defaults and timer state type for the traffic-light controller and its interval timer.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package traffic_pkg;

    typedef enum logic [1:0] {
        T_BASE    = 2'b00,
        T_EXT     = 2'b01,
        T_YEL     = 2'b10,
        T_BASE_X2 = 2'b11
    } interval_t;

    typedef enum logic [1:0] {
        SEL_BASE = 2'b00,
        SEL_EXT  = 2'b01,
        SEL_YEL  = 2'b10,
        SEL_NONE = 2'b11
    } selector_t;

    localparam int unsigned DEFAULT_BASE = 6;
    localparam int unsigned DEFAULT_EXT  = 3;
    localparam int unsigned DEFAULT_YEL  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

    typedef struct packed {
        logic [3:0] base;
        logic [3:0] ext;
        logic [3:0] yel;
    } time_params_t;

    // 5 bits so that 2 x 15 s fits without wrapping.
    function automatic logic [4:0] load_value(input interval_t code, input time_params_t p);
        logic [4:0] v;
        v = {1'b0, p.base};
        case (code)
            T_BASE:    v = {1'b0, p.base};
            T_EXT:     v = {1'b0, p.ext};
            T_YEL:     v = {1'b0, p.yel};
            T_BASE_X2: v = {p.base, 1'b0};
            default:   v = {1'b0, p.base};
        endcase
        return v;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Seconds prescaler: counts 0..TICK_CYCLES-1 while enabled, synchronous clear back to 0.
// Latency: o_tick is combinational from the count, high in the last cycle of each period.
// Backpressure: none; i_clr overrides i_en and suppresses the tick.
module tick_gen #(
    parameter int unsigned TICK_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int unsigned W = $clog2(TICK_CYCLES);
    localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);

    logic [W-1:0] r_cnt;
    logic         w_wrap;

    assign w_wrap = (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && !i_clr && w_wrap;

endmodule

// File: rtl/interval_timer.sv
// Whole-second countdown timer with programmable base/ext/yellow times; optional `remaining` via INTERVAL_TIMER_REMAIN_EN.
// Latency: busy one edge after start_timer; expired pulses the cycle after edge start + N*TICK_CYCLES.
// Backpressure: none; Prog_Sync aborts, start_timer restarts, both override the running count.
module interval_timer
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 100_000_000,
    parameter int unsigned DEF_BASE    = DEFAULT_BASE,
    parameter int unsigned DEF_EXT     = DEFAULT_EXT,
    parameter int unsigned DEF_YEL     = DEFAULT_YEL
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic [1:0] interval,
    input  logic       start_timer,
    input  logic       Prog_Sync,
    input  logic [1:0] Selector,
    input  logic [3:0] Time_Value,
`ifdef INTERVAL_TIMER_REMAIN_EN
    output logic [4:0] remaining,
`endif
    output logic       expired,
    output logic       busy
);

    localparam logic [3:0] W_DEF_BASE = 4'(DEF_BASE);
    localparam logic [3:0] W_DEF_EXT  = 4'(DEF_EXT);
    localparam logic [3:0] W_DEF_YEL  = 4'(DEF_YEL);

    time_params_t r_par;
    timer_state_t r_state;
    logic [4:0]   r_count;
    logic         r_expired;
    logic         r_busy;

    logic [4:0]   w_load;
    logic         w_tick;
    logic         w_presc_clr;
    logic         w_running;

    assign w_load      = load_value(interval_t'(interval), r_par);
    assign w_running   = (r_state == RUN);
    // Any load, abort or idle cycle restarts the prescaler so each second is full length.
    assign w_presc_clr = Prog_Sync || start_timer || !w_running;

    tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (Reset_n),
        .i_clr (w_presc_clr),
        .i_en  (w_running),
        .o_tick(w_tick)
    );

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_par <= '{base: W_DEF_BASE, ext: W_DEF_EXT, yel: W_DEF_YEL};
        end else if (Prog_Sync) begin
            case (selector_t'(Selector))
                SEL_BASE: r_par.base <= (Time_Value == 4'd0) ? W_DEF_BASE : Time_Value;
                SEL_EXT:  r_par.ext  <= (Time_Value == 4'd0) ? W_DEF_EXT  : Time_Value;
                SEL_YEL:  r_par.yel  <= (Time_Value == 4'd0) ? W_DEF_YEL  : Time_Value;
                default:  r_par      <= r_par;
            endcase
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_expired <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_expired <= 1'b0;
            if (Prog_Sync) begin
                r_state <= IDLE;
                r_count <= '0;
                r_busy  <= 1'b0;
            end else if (start_timer) begin
                r_state <= RUN;
                r_count <= w_load;
                r_busy  <= 1'b1;
            end else if (w_running && w_tick) begin
                if (r_count <= 5'd1) begin
                    r_state   <= IDLE;
                    r_count   <= '0;
                    r_busy    <= 1'b0;
                    r_expired <= 1'b1;
                end else begin
                    r_count <= r_count - 5'd1;
                end
            end
        end
    end

    assign expired = r_expired;
    assign busy    = r_busy;

`ifdef INTERVAL_TIMER_REMAIN_EN
    assign remaining = r_count;
`endif

endmodule

// File: tb/tb_interval_timer.sv
// Bench for interval_timer at TICK_CYCLES=4: directed scenarios with literal latencies plus a random phase,
// all cycles compared against a deadline-based model.
module tb_interval_timer;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       Reset_n = 1'b1;
    logic [1:0] interval = 2'd0;
    logic       start_timer = 1'b0;
    logic       Prog_Sync = 1'b0;
    logic [1:0] Selector = 2'd3;
    logic [3:0] Time_Value = 4'd0;
    logic       expired;
    logic       busy;
`ifdef INTERVAL_TIMER_REMAIN_EN
    logic [4:0] remaining;
`endif

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    interval_timer #(
        .TICK_CYCLES(T),
        .DEF_BASE   (6),
        .DEF_EXT    (3),
        .DEF_YEL    (2)
    ) dut (
        .clk        (clk),
        .Reset_n    (Reset_n),
        .interval   (interval),
        .start_timer(start_timer),
        .Prog_Sync  (Prog_Sync),
        .Selector   (Selector),
        .Time_Value (Time_Value),
`ifdef INTERVAL_TIMER_REMAIN_EN
        .remaining  (remaining),
`endif
        .expired    (expired),
        .busy       (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a running count is just a start edge, a length and an absolute deadline edge.
    int defs[3] = '{6, 3, 2};
    int m_par[3] = '{6, 3, 2};
    int k = 0;
    int m_start = 0;
    int m_end = 0;
    int m_load = 0;
    bit m_run = 1'b0;
    bit m_exp = 1'b0;

    function automatic int load_of(input int code);
        return (code == 3) ? 2 * m_par[0] : m_par[code];
    endfunction

    always @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_run <= 1'b0;
            m_exp <= 1'b0;
            for (int i = 0; i < 3; i++) m_par[i] <= defs[i];
        end else begin
            k     <= k + 1;
            m_exp <= m_run && (k == m_end) && !Prog_Sync && !start_timer;
            if (Prog_Sync) begin
                m_run <= 1'b0;
                if (int'(Selector) != 3)
                    m_par[int'(Selector)] <= (Time_Value == 4'd0) ? defs[int'(Selector)] : int'(Time_Value);
            end else if (start_timer) begin
                m_run   <= 1'b1;
                m_load  <= load_of(int'(interval));
                m_start <= k;
                m_end   <= k + load_of(int'(interval)) * T;
            end else if (m_run && k == m_end) begin
                m_run <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", int'(busy), int'(m_run));
            check("expired", int'(expired), int'(m_exp));
`ifdef INTERVAL_TIMER_REMAIN_EN
            check("remaining", int'(remaining), m_run ? m_load - (k - 1 - m_start) / T : 0);
`endif
        end
    end

    // Called at a negedge; returns at the negedge right after the sampling edge E0.
    task automatic do_start(input int code);
        start_timer = 1'b1;
        interval    = 2'(code);
        @(posedge clk);
        @(negedge clk);
        start_timer = 1'b0;
    endtask

    task automatic prog(input int sel, input int val);
        Prog_Sync  = 1'b1;
        Selector   = 2'(sel);
        Time_Value = 4'(val);
        @(negedge clk);
        Prog_Sync  = 1'b0;
        Selector   = 2'd3;
    endtask

    // n = number of edges after the start edge until expired is seen; 200 means it never came.
    task automatic wait_expired(output int n);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (expired) break;
        end
    endtask

    initial begin
        int n;
        int seen;

        #3 Reset_n = 1'b0;
        #1 chk_en = 1'b1;
        check("reset_busy", int'(busy), 0);
        check("reset_expired", int'(expired), 0);
        repeat (2) @(negedge clk);
        Reset_n = 1'b1;

        do_start(0);
        wait_expired(n);
        check("default_base_latency", n, 24);
        check("busy_low_at_pulse", int'(busy), 0);
        @(negedge clk);
        check("pulse_one_cycle", int'(expired), 0);

        prog(0, 5);
        do_start(3);
`ifdef INTERVAL_TIMER_REMAIN_EN
        check("remaining_after_load", int'(remaining), 10);
`endif
        wait_expired(n);
        check("base_x2_latency", n, 40);

        prog(2, 0);
        prog(3, 9);
        do_start(2);
        wait_expired(n);
        check("yel_default_latency", n, 8);
        do_start(0);
        wait_expired(n);
        check("base_unchanged_latency", n, 20);

        do_start(1);
        repeat (10) @(negedge clk);
        start_timer = 1'b1;
        interval    = 2'd2;
        @(posedge clk);
        @(negedge clk);
        start_timer = 1'b0;
        wait_expired(n);
        check("retrigger_latency", n, 8);

        do_start(0);
        repeat (4) @(negedge clk);
        Prog_Sync   = 1'b1;
        Selector    = 2'd3;
        start_timer = 1'b1;
        interval    = 2'd0;
        repeat (3) @(negedge clk);
        Prog_Sync = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start_timer = 1'b0;
        wait_expired(n);
        check("abort_restart_latency", n, 20);

        do_start(0);
        repeat (9) @(negedge clk);
        #2 Reset_n = 1'b0;
        #1;
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_expired", int'(expired), 0);
        repeat (2) @(negedge clk);
        Reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (expired) seen++;
        end
        check("no_pulse_after_reset", seen, 0);
        do_start(0);
        wait_expired(n);
        check("defaults_after_reset", n, 24);

        repeat (2500) begin
            @(negedge clk);
            start_timer = ($urandom_range(0, 59) == 0);
            Prog_Sync   = ($urandom_range(0, 149) == 0);
            Selector    = 2'($urandom_range(0, 3));
            Time_Value  = 4'($urandom_range(0, 15));
            interval    = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        start_timer = 1'b0;
        Prog_Sync   = 1'b0;
        repeat (130) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
